heap_overflow_tracker: RTL and testbench
========================================

# heap_overflow_tracker

Sequencing controller for the overflow-range circular buffer beside the branch unit. It watches the executing store, load and JALR stream and groups contiguous non-stack stores into runs. Runs longer than a threshold are committed into the range buffer through a valid/ready write handshake. A load that falls in a tracked or stored range, followed by a JALR, raises a crash request; the branch unit uses it to redirect the target to zero.

## Interface
Parameters:
- `ADDR_W`, 32, address width (VLEN)
- `MIN_RUN_BYTES`, 32, a run commits only when its byte count is strictly greater than this
- `TIMEOUT`, 10, idle cycles allowed before an open run is closed

Ports:
- `clk_i`  in  1  clock, rising edge
- `rst_ni`  in  1  asynchronous active-low reset
- `store_valid_i`  in  1  a store (SW/SH/SB) is executing this cycle
- `store_addr_i`  in  ADDR_W  effective store address (imm + rs1)
- `store_size_i`  in  3  store bytes: 1, 2 or 4
- `store_rs1_i`  in  5  base register index of the store
- `load_valid_i`  in  1  a load (LW/LH/LB) is executing this cycle
- `load_addr_i`  in  ADDR_W  effective load address
- `buffer_hit_i`  in  1  range buffer reports `load_addr_i` inside a stored range (combinational)
- `jalr_valid_i`  in  1  a JALR is executing this cycle
- `en_crash_i`  in  1  crash enable (debug switch)
- `buf_write_o`  out  1  commit request to the range buffer
- `buf_ready_i`  in  1  range buffer accepts the commit
- `buf_first_o`  out  ADDR_W  first address of the committed run
- `buf_last_o`  out  ADDR_W  last store address of the committed run
- `active_o`  out  1  a run is open (state TRACK)
- `load_in_range_o`  out  1  the last load hit a tracked or stored range
- `crash_o`  out  1  one-cycle crash request

## Operation
- A store qualifies when `store_valid_i` is high and `store_rs1_i` is neither 2 (sp) nor 8 (fp).
- Run registers: `start`, `end`, `last_size`, `count` (32 bit, saturating), and `date` (width `$clog2(TIMEOUT+1)`).
- State machine:
  - **IDLE**
    - On a qualifying store, go to TRACK.
    - Load `start = end = addr`, `count = size`, `last_size = size`, `date = TIMEOUT`.
  - **TRACK**
    - Contiguity is tested as `addr == end + last_size`, computed in ADDR_W+1 bits. A carry-out counts as non-contiguous; runs never wrap through 0.
    - A contiguous qualifying store extends the run: `end = addr`, `count += size`, `last_size = size`, `date = TIMEOUT`.
    - A non-contiguous qualifying store closes the run. That store is dropped and does not start a new run.
    - A cycle with no qualifying store: if `date != 0`, decrement `date`. If `date == 0`, close the run.
    - On close: if `count > MIN_RUN_BYTES`, latch `buf_first_o = start` and `buf_last_o = end`, then go to COMMIT. Otherwise go to IDLE.
  - **COMMIT**
    - `buf_write_o` is high. `buf_first_o` and `buf_last_o` hold stable until the handshake.
    - Qualifying stores are ignored.
    - When `buf_write_o && buf_ready_i`, the transfer completes and the next state is IDLE.
- Load tracking:
  - If `load_valid_i` is high and `store_valid_i` is low, register `load_in_range = buffer_hit_i || (state==TRACK && start <= load_addr_i <= end)`.
  - The value holds until the next load or a JALR.
- Crash:
  - If `jalr_valid_i && load_in_range_q && en_crash_i`, `crash_o` goes high for exactly the next cycle.
  - Any JALR clears `load_in_range_q`.
- Simultaneous events:
  - Store and load in the same cycle: the store is processed and the load is ignored.
  - JALR is evaluated independently, using `load_in_range_q` from before the cycle.
- Reset, asynchronous, from any state:
  - State returns to IDLE and all registers clear.
  - An in-flight commit is abandoned.

## Timing
- All outputs are registered. Reset value of every output is 0.
- `active_o` is high the cycle after the first qualifying store.
- Timeout: with `TIMEOUT = 10`, the run closes on the 11th consecutive non-qualifying cycle. `buf_write_o` rises on the following cycle.
- Non-contiguous close: `buf_write_o` rises on the cycle after the closing store.
- Commit latency is 1 cycle minimum. Backpressure from `buf_ready_i` is unbounded.
- `crash_o` is high 1 cycle after the JALR.
- `load_in_range_o` updates 1 cycle after the load.

## Test plan
1. Nine SW at 0x1000..0x1020, step 4, rs1=10, then idle.
   - Required: count reaches 36.
   - Required: `buf_write_o` rises 12 cycles after the last store, with `buf_first_o=0x1000` and `buf_last_o=0x1020`.
   - With `buf_ready_i=1`, the state is IDLE the next cycle.
2. Eight SW at 0x2000..0x201C (count 32), then SW at 0x3000.
   - Required: no commit, next state IDLE.
   - Required: a following SW to 0x3004 opens a fresh run with `start=0x3004`.
3. Twenty SW at consecutive addresses with rs1=2, then the same with rs1=8.
   - Required: `active_o` stays 0 and no commit occurs.
4. Run from scenario 1 reaches COMMIT with `buf_ready_i=0` for 5 cycles, while contiguous stores continue.
   - Required: `buf_write_o`, `buf_first_o` and `buf_last_o` are stable throughout, and the stores are ignored.
   - Required: the handshake completes on cycle 6.
5. During TRACK (`start=0x1000`, `end=0x1010`), LW at 0x1008, then JALR.
   - With `en_crash_i=1`: `load_in_range_o=1`, then a one-cycle `crash_o` pulse, and `load_in_range_o` clears.
   - Repeat with `en_crash_i=0`: no crash.
   - Repeat with LW at 0x2000 and `buffer_hit_i=1`: crash.
6. Assert `rst_ni` low mid-TRACK and again mid-COMMIT.
   - Required: all outputs 0 immediately, state IDLE, no commit issued after release.
7. SW at 0xFFFFFFFC, then SW at 0x00000000.
   - Required: treated as non-contiguous, the run closes, and no commit occurs.

Source files
------------

// File: rtl/heap_overflow_tracker.sv
// Groups contiguous non-stack stores into runs and commits long runs
// to the range buffer; flags load-then-JALR hits as crash requests.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   store_valid_i/addr/size  executing store (size in bytes: 1/2/4)
//   store_rs1_i              store base register (sp/fp stores skipped)
//   load_valid_i/addr        executing load
//   buffer_hit_i             range buffer hit for load_addr_i
//   jalr_valid_i             executing JALR
//   en_crash_i               crash enable
//   buf_write_o/buf_ready_i  commit handshake to the range buffer
//   buf_first_o/buf_last_o   committed run bounds
//   active_o                 a run is open
//   load_in_range_o          last load hit a tracked or stored range
//   crash_o                  one-cycle crash request
module heap_overflow_tracker #(
  parameter int ADDR_W        = 32,
  parameter int MIN_RUN_BYTES = 32,
  parameter int TIMEOUT       = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              store_valid_i,
  input  logic [ADDR_W-1:0] store_addr_i,
  input  logic [2:0]        store_size_i,
  input  logic [4:0]        store_rs1_i,
  input  logic              load_valid_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic              buffer_hit_i,
  input  logic              jalr_valid_i,
  input  logic              en_crash_i,
  output logic              buf_write_o,
  input  logic              buf_ready_i,
  output logic [ADDR_W-1:0] buf_first_o,
  output logic [ADDR_W-1:0] buf_last_o,
  output logic              active_o,
  output logic              load_in_range_o,
  output logic              crash_o
);

  localparam int DATE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [2:0]        last_size_q, last_size_d;
  logic [31:0]       count_q, count_d;
  logic [DATE_W-1:0] date_q, date_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              lir_q, lir_d;
  logic              crash_q, crash_d;

  logic              qualify;
  logic [ADDR_W:0]   next_addr;
  logic              contig;
  logic [32:0]       count_sum;
  logic [31:0]       count_sat;
  logic              close_run;
  logic              run_big;
  logic              in_run;

  // Stores through sp (x2) or fp (x8) are stack traffic.
  assign qualify = store_valid_i
                && (store_rs1_i != 5'd2)
                && (store_rs1_i != 5'd8);

  // Carry into bit ADDR_W means the run would wrap through 0.
  assign next_addr = {1'b0, end_q}
                   + {{(ADDR_W-2){1'b0}}, last_size_q};
  assign contig = !next_addr[ADDR_W]
               && (next_addr[ADDR_W-1:0] == store_addr_i);

  assign count_sum = {1'b0, count_q}
                   + {30'd0, store_size_i};
  assign count_sat = count_sum[32] ? '1
                   : count_sum[31:0];

  assign close_run = qualify ? !contig
                   : (date_q == '0);
  assign run_big = count_q > 32'(MIN_RUN_BYTES);

  assign in_run = (state_q == TRACK)
               && (start_q <= load_addr_i)
               && (load_addr_i <= end_q);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (qualify) state_d = TRACK;
      end
      TRACK: begin
        if (close_run) begin
          state_d = run_big ? COMMIT : IDLE;
        end
      end
      COMMIT: begin
        if (buf_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    buf_write_o     = (state_q == COMMIT);
    active_o        = (state_q == TRACK);
    buf_first_o     = first_q;
    buf_last_o      = last_q;
    load_in_range_o = lir_q;
    crash_o         = crash_q;
  end

  // Run datapath
  always_comb begin
    start_d     = start_q;
    end_d       = end_q;
    last_size_d = last_size_q;
    count_d     = count_q;
    date_d      = date_q;
    first_d     = first_q;
    last_d      = last_q;
    unique case (state_q)
      IDLE: begin
        if (qualify) begin
          start_d     = store_addr_i;
          end_d       = store_addr_i;
          last_size_d = store_size_i;
          count_d     = {29'd0, store_size_i};
          date_d      = DATE_W'(TIMEOUT);
        end
      end
      TRACK: begin
        if (qualify && contig) begin
          end_d       = store_addr_i;
          last_size_d = store_size_i;
          count_d     = count_sat;
          date_d      = DATE_W'(TIMEOUT);
        end else if (!qualify && date_q != '0) begin
          date_d = date_q - DATE_W'(1);
        end
        if (close_run && run_big) begin
          first_d = start_q;
          last_d  = end_q;
        end
      end
      default: ;
    endcase
  end

  // Load tracking and crash request.
  // A store in the same cycle hides the load.
  always_comb begin
    lir_d = lir_q;
    if (jalr_valid_i) lir_d = 1'b0;
    if (load_valid_i && !store_valid_i) begin
      lir_d = buffer_hit_i || in_run;
    end
    crash_d = jalr_valid_i && lir_q && en_crash_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q     <= '0;
      end_q       <= '0;
      last_size_q <= '0;
      count_q     <= '0;
      date_q      <= '0;
      first_q     <= '0;
      last_q      <= '0;
      lir_q       <= 1'b0;
      crash_q     <= 1'b0;
    end else begin
      start_q     <= start_d;
      end_q       <= end_d;
      last_size_q <= last_size_d;
      count_q     <= count_d;
      date_q      <= date_d;
      first_q     <= first_d;
      last_q      <= last_d;
      lir_q       <= lir_d;
      crash_q     <= crash_d;
    end
  end

endmodule

// File: tb/tb_heap_overflow_tracker.sv
// Directed bench for heap_overflow_tracker: vector table for load/JALR
// behaviour plus hand sequences for commit, timeout and reset cases.
module tb_heap_overflow_tracker;

  logic        clk;
  logic        rst_n;
  logic        st_v;
  logic [31:0] st_a;
  logic [2:0]  st_s;
  logic [4:0]  st_r;
  logic        ld_v;
  logic [31:0] ld_a;
  logic        hit;
  logic        jv;
  logic        en;
  logic        wr;
  logic        rdy;
  logic [31:0] first;
  logic [31:0] last;
  logic        act;
  logic        lir;
  logic        crash;

  int n_cmp = 0;
  int n_bad = 0;

  heap_overflow_tracker dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .store_valid_i  (st_v),
    .store_addr_i   (st_a),
    .store_size_i   (st_s),
    .store_rs1_i    (st_r),
    .load_valid_i   (ld_v),
    .load_addr_i    (ld_a),
    .buffer_hit_i   (hit),
    .jalr_valid_i   (jv),
    .en_crash_i     (en),
    .buf_write_o    (wr),
    .buf_ready_i    (rdy),
    .buf_first_o    (first),
    .buf_last_o     (last),
    .active_o       (act),
    .load_in_range_o(lir),
    .crash_o        (crash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [31:0] sa;
    logic        lv;
    logic [31:0] la;
    logic        hit;
    logic        jv;
    logic        en;
    logic        e_act;
    logic        e_lir;
    logic        e_crash;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic sv, logic [31:0] sa,
    logic lv, logic [31:0] la,
    logic h, logic j, logic e,
    logic ea, logic el, logic ec);
    vec_t x;
    x.sv = sv; x.sa = sa;
    x.lv = lv; x.la = la;
    x.hit = h; x.jv = j; x.en = e;
    x.e_act = ea; x.e_lir = el;
    x.e_crash = ec;
    return x;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               nm, a, e);
    end
  endtask

  task automatic clr();
    st_v = 0; st_a = 0; st_s = 3'd4;
    st_r = 5'd10; ld_v = 0; ld_a = 0;
    hit = 0; jv = 0; en = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a,
                       input logic [4:0] r);
    st_v = 1; st_a = a; st_s = 3'd4; st_r = r;
  endtask

  // Nine SW from base, then timeout to COMMIT.
  task automatic run9(input logic [31:0] base,
                      input string nm);
    for (int i = 0; i < 9; i++) begin
      store(base + 32'(4 * i), 5'd10);
      step();
    end
    clr();
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 10) chk({nm, "_early"}, wr, 0);
    end
    chk({nm, "_wr"}, wr, 1);
    chk({nm, "_first"}, first, base);
    chk({nm, "_last"}, last, base + 32'd32);
  endtask

  task automatic all_zero(input string nm);
    chk({nm, "_wr"}, wr, 0);
    chk({nm, "_act"}, act, 0);
    chk({nm, "_lir"}, lir, 0);
    chk({nm, "_crash"}, crash, 0);
    chk({nm, "_first"}, first, 0);
    chk({nm, "_last"}, last, 0);
  endtask

  initial begin
    tbl.push_back(mk(1,'h1000,0,0,0,0,1, 1,0,0));
    tbl.push_back(mk(1,'h1004,0,0,0,0,1, 1,0,0));
    tbl.push_back(mk(1,'h1008,0,0,0,0,1, 1,0,0));
    tbl.push_back(mk(1,'h100C,0,0,0,0,1, 1,0,0));
    tbl.push_back(mk(1,'h1010,0,0,0,0,1, 1,0,0));
    tbl.push_back(mk(0,0,1,'h1008,0,0,1, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0,1,1, 1,0,1));
    tbl.push_back(mk(0,0,1,'h1008,0,0,0, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0,1,0, 1,0,0));
    tbl.push_back(mk(0,0,1,'h2000,1,0,1, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0,1,1, 1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,1, 1,0,0));
    tbl.push_back(mk(0,0,1,'h1014,0,0,1, 1,0,0));
    tbl.push_back(mk(0,0,1,'h1010,0,0,1, 1,1,0));
    tbl.push_back(mk(0,0,1,'h0FFC,0,0,1, 1,0,0));
    tbl.push_back(mk(1,'h1014,1,'h2000,1,0,1, 1,0,0));
    tbl.push_back(mk(0,0,1,'h1014,0,0,1, 1,1,0));

    clr();
    rdy = 0;
    rst_n = 0;
    #12;
    all_zero("reset");
    rst_n = 1;
    step();

    // 1: 36-byte run commits after timeout
    run9(32'h1000, "s1");
    rdy = 1;
    step();
    chk("s1_done_wr", wr, 0);
    chk("s1_done_act", act, 0);
    rdy = 0;

    // 2: 32-byte run closed by a jump, no commit
    for (int i = 0; i < 8; i++) begin
      store(32'h2000 + 32'(4 * i), 5'd10);
      step();
    end
    store(32'h3000, 5'd10);
    step();
    chk("s2_act", act, 0);
    chk("s2_wr", wr, 0);
    run9(32'h3004, "s2b");
    rdy = 1;
    step();
    rdy = 0;
    chk("s2b_done", wr, 0);

    // 3: stack stores never open a run
    for (int i = 0; i < 40; i++) begin
      store(32'h4000 + 32'(4 * i),
            (i < 20) ? 5'd2 : 5'd8);
      step();
      chk($sformatf("s3_act%0d", i), act, 0);
    end
    clr();
    for (int k = 0; k < 12; k++) step();
    chk("s3_wr", wr, 0);

    // 4: backpressure with stores arriving
    run9(32'h1000, "s4");
    for (int c = 0; c < 5; c++) begin
      store(32'h1024 + 32'(4 * c), 5'd10);
      step();
      chk($sformatf("s4_wr%0d", c), wr, 1);
      chk($sformatf("s4_f%0d", c), first, 32'h1000);
      chk($sformatf("s4_l%0d", c), last, 32'h1020);
      chk($sformatf("s4_a%0d", c), act, 0);
    end
    store(32'h1038, 5'd10);
    rdy = 1;
    step();
    chk("s4_done_wr", wr, 0);
    chk("s4_done_act", act, 0);
    rdy = 0;
    clr();
    step();

    // 5: load / JALR table
    foreach (tbl[i]) begin
      st_v = tbl[i].sv; st_a = tbl[i].sa;
      ld_v = tbl[i].lv; ld_a = tbl[i].la;
      hit = tbl[i].hit; jv = tbl[i].jv;
      en = tbl[i].en;
      step();
      chk($sformatf("v%0d_act", i), act, tbl[i].e_act);
      chk($sformatf("v%0d_lir", i), lir, tbl[i].e_lir);
      chk($sformatf("v%0d_crash", i), crash,
          tbl[i].e_crash);
    end
    clr();
    for (int k = 0; k < 12; k++) step();
    chk("s5_act", act, 0);
    chk("s5_wr", wr, 0);

    // 7: no wrap through address 0
    store(32'hFFFF_FFFC, 5'd10);
    step();
    chk("s7_act0", act, 1);
    store(32'h0000_0000, 5'd10);
    step();
    chk("s7_act1", act, 0);
    clr();
    for (int k = 0; k < 13; k++) step();
    chk("s7_wr", wr, 0);

    // 6a: reset mid-TRACK with a load hit held
    store(32'h1000, 5'd10);
    step();
    store(32'h1004, 5'd10);
    step();
    clr();
    ld_v = 1; ld_a = 32'h1000;
    step();
    clr();
    chk("s6a_pre_lir", lir, 1);
    #2 rst_n = 0;
    #1 all_zero("s6a");
    #3 rst_n = 1;
    for (int k = 0; k < 15; k++) step();
    chk("s6a_wr", wr, 0);
    chk("s6a_act", act, 0);

    // 6b: reset mid-COMMIT
    run9(32'h5000, "s6b");
    #2 rst_n = 0;
    #1 all_zero("s6b");
    #3 rst_n = 1;
    for (int k = 0; k < 15; k++) begin
      step();
      if (wr) chk("s6b_after", wr, 0);
    end
    chk("s6b_end_wr", wr, 0);
    chk("s6b_end_act", act, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
